// File: rtl/ctrl_frame_sequencer.sv
// ctrl_frame_sequencer: sole driver of the control-frame stack.
// Turns decoded control ops (PUSH, END, BR L, RETURN) into push/pop sequences,
// one stack access per cycle, and reports the resolved control-flow target.
// Frame = {type[14:13], retu_num[12], sp_tag[11:8], retu_addr[7:0]}.
//
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
// cmd_ready is high only in IDLE, so the decoder must hold cmd_valid and its
// payload stable until that edge. Each accepted command produces exactly one
// done_valid pulse, unless reset intervenes.
module ctrl_frame_sequencer #(
  parameter int FRAME_W = 15,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [FRAME_W-1:0] cmd_frame,
  input  logic [CNT_W-1:0]   cmd_depth,
  output logic               stk_push,
  output logic               stk_pop,
  output logic [FRAME_W-1:0] stk_push_data,
  input  logic [FRAME_W-1:0] stk_top_data,
  output logic               done_valid,
  output logic               done_jump,
  output logic [7:0]         done_addr,
  output logic [3:0]         done_sp_tag,
  output logic               done_retu_num,
  output logic               done_err,
  output logic [CNT_W-1:0]   occupancy,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PUSH = 2'd1,
    S_WALK = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] OP_PUSH   = 2'b00;
  localparam logic [1:0] OP_END    = 2'b01;
  localparam logic [1:0] OP_BR     = 2'b10;
  localparam logic [1:0] OP_RET    = 2'b11;
  localparam logic [1:0] TYPE_CALL = 2'b01;
  localparam logic [1:0] TYPE_LOOP = 2'b11;
  localparam logic [CNT_W-1:0] OCC_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] OCC_ONE  = CNT_W'(1);

  state_t             r_state, w_nxt_state;
  logic [1:0]         r_op, w_nxt_op;
  logic [FRAME_W-1:0] r_frame, w_nxt_frame;
  logic [CNT_W-1:0]   r_cnt, w_nxt_cnt;
  logic [CNT_W-1:0]   r_occ;
  logic [FRAME_W-1:0] r_res, w_nxt_res;
  logic               r_jump, w_nxt_jump;
  logic               r_err, w_nxt_err;
  logic               w_push, w_pop;
  logic [1:0]         w_top_type;
  logic               w_is_done;

  assign w_top_type = stk_top_data[FRAME_W-1 -: 2];
  assign w_is_done  = (r_state == S_DONE);

  // Next-state, strobe and result-capture decode
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_op    = r_op;
    w_nxt_frame = r_frame;
    w_nxt_cnt   = r_cnt;
    w_nxt_res   = r_res;
    w_nxt_jump  = r_jump;
    w_nxt_err   = r_err;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_nxt_op    = cmd_op;
          w_nxt_frame = cmd_frame;
          w_nxt_cnt   = cmd_depth;
          w_nxt_res   = cmd_frame;
          w_nxt_jump  = 1'b0;
          w_nxt_err   = 1'b0;
          if (cmd_op == OP_PUSH) begin
            if (r_occ == OCC_FULL) begin
              w_nxt_err   = 1'b1;
              w_nxt_state = S_DONE;
            end else begin
              w_nxt_state = S_PUSH;
            end
          end else if ((r_occ == '0) || ((cmd_op == OP_BR) && (cmd_depth >= r_occ))) begin
            // Nothing to pop or label out of range: report without touching the stack.
            w_nxt_res   = '0;
            w_nxt_err   = 1'b1;
            w_nxt_state = S_DONE;
          end else begin
            w_nxt_state = S_WALK;
          end
        end
      end
      S_PUSH: begin
        w_push      = 1'b1;
        w_nxt_res   = r_frame;
        w_nxt_jump  = 1'b0;
        w_nxt_state = S_DONE;
      end
      S_WALK: begin
        case (r_op)
          OP_END: begin
            w_pop       = 1'b1;
            w_nxt_res   = stk_top_data;
            w_nxt_jump  = (w_top_type == TYPE_CALL);
            w_nxt_state = S_DONE;
          end
          OP_BR: begin
            if (r_cnt != '0) begin
              w_pop     = 1'b1;
              w_nxt_cnt = r_cnt - OCC_ONE;
            end else begin
              // Target frame: a loop frame stays so the loop can iterate again.
              w_pop       = (w_top_type != TYPE_LOOP);
              w_nxt_res   = stk_top_data;
              w_nxt_jump  = 1'b1;
              w_nxt_state = S_DONE;
            end
          end
          OP_RET: begin
            w_pop = 1'b1;
            if (w_top_type == TYPE_CALL) begin
              w_nxt_res   = stk_top_data;
              w_nxt_jump  = 1'b1;
              w_nxt_state = S_DONE;
            end else if (r_occ == OCC_ONE) begin
              // Last frame popped and no call frame found.
              w_nxt_res   = '0;
              w_nxt_err   = 1'b1;
              w_nxt_state = S_DONE;
            end
          end
          default: w_nxt_state = S_DONE;
        endcase
      end
      S_DONE:  w_nxt_state = S_IDLE;
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // State, latched command, result and occupancy registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= OP_PUSH;
      r_frame <= '0;
      r_cnt   <= '0;
      r_occ   <= '0;
      r_res   <= '0;
      r_jump  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_op    <= w_nxt_op;
      r_frame <= w_nxt_frame;
      r_cnt   <= w_nxt_cnt;
      r_res   <= w_nxt_res;
      r_jump  <= w_nxt_jump;
      r_err   <= w_nxt_err;
      if (w_push && (r_occ != OCC_FULL)) begin
        r_occ <= r_occ + OCC_ONE;
      end else if (w_pop && (r_occ != '0)) begin
        r_occ <= r_occ - OCC_ONE;
      end
    end
  end

  assign cmd_ready     = (r_state == S_IDLE);
  assign stk_push      = w_push;
  assign stk_pop       = w_pop;
  assign stk_push_data = r_frame;
  assign done_valid    = w_is_done;
  assign done_jump     = w_is_done & r_jump;
  assign done_err      = w_is_done & r_err;
  assign done_addr     = w_is_done ? r_res[7:0]  : 8'h00;
  assign done_sp_tag   = w_is_done ? r_res[11:8] : 4'h0;
  assign done_retu_num = w_is_done & r_res[12];
  assign occupancy     = r_occ;
  assign dbg_state     = r_state;

endmodule
